// File: rtl/pipelined_rca_if.sv
// pipelined_rca_if
// ----------------
// Streaming bus for the pipelined ripple-carry adder. It carries the operand
// side (valid/ready, x, y, cin, op) and the result side (valid/ready, sum,
// cout). When PIPELINED_RCA_OVF_EN is defined it also carries the signed
// overflow flag ovf.
//
// Modports:
//   master : producer/consumer side. Drives operands and out_ready, and
//            observes in_ready and the result.
//   slave  : the adder. Accepts operands and drives in_ready and the result.
//
// Parameter:
//   WIDTH  : operand/result width in bits.
interface pipelined_rca_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_RCA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid,
    output x,
    output y,
    output cin,
    output op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
`ifdef PIPELINED_RCA_OVF_EN
    input  ovf,
`endif
    input  cout
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  cin,
    input  op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
`ifdef PIPELINED_RCA_OVF_EN
    output ovf,
`endif
    output cout
  );
endinterface

// File: rtl/pipelined_rca.sv
// pipelined_rca
// -------------
// Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is split
// into STAGES equal slices of CHUNK = WIDTH/STAGES bits. Each pipeline stage
// adds one slice and forwards its carry to the next stage. The remaining
// upper operand bits and the lower result bits that are already finished
// travel along with the operation. One operation per cycle is sustained, and
// the latency is STAGES cycles.
//
// op = 0 : {cout,sum} = x + y + cin
// op = 1 : {cout,sum} = x + ~y + 1 (cin ignored). cout = 1 means no borrow.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset. It clears all in-flight work.
//   bus   : pipelined_rca_if.slave
//           in_valid/in_ready/x/y/cin/op        operand handshake
//           out_valid/out_ready/sum/cout [/ovf] result handshake
//
// Parameters:
//   WIDTH  : operand width. It must be a multiple of STAGES.
//   STAGES : pipeline depth, >= 1.
//
// Optional feature (macro PIPELINED_RCA_OVF_EN):
//   Adds the registered signed-overflow flag bus.ovf, which equals the carry
//   into the MSB XOR the carry out of the MSB.
//
// Flow control: only the output stage can stall. A stall occurs when
// out_valid && !out_ready. While stalled, every stage holds its value and
// in_ready drops combinationally. Empty stages move forward as bubbles.
module pipelined_rca #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipelined_rca_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CHUNK-1:0] chunk_t;
  typedef logic [CHUNK:0]   slice_t;

  // Ripple add of one slice. The result is {carry_out, slice_sum}.
  function automatic slice_t add_slice(input chunk_t a, input chunk_t b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
  endfunction

`ifdef PIPELINED_RCA_OVF_EN
  // Signed overflow of the top slice. The carry into the MSB is recovered
  // as sum_msb ^ a_msb ^ b_msb.
  function automatic logic slice_ovf(input chunk_t a, input chunk_t b, input logic c);
    slice_t s;
    s = add_slice(a, b, c);
    return s[CHUNK] ^ (s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1]);
  endfunction
`endif

  // Stage registers. Stage k holds the operands with y already inverted for
  // subtraction, the result bits [0 .. (k+1)*CHUNK-1] and the carry out of
  // slice k.
  logic   v_r   [STAGES];
  word_t  a_r   [STAGES];
  word_t  b_r   [STAGES];
  word_t  res_r [STAGES];
  logic   c_r   [STAGES];

  // Next-state values of the stage registers.
  logic   v_s   [STAGES];
  word_t  a_s   [STAGES];
  word_t  b_s   [STAGES];
  word_t  res_s [STAGES];
  logic   c_s   [STAGES];

  // Per-stage slice operands, the load enable and the slice adder output.
  chunk_t in_a_s  [STAGES];
  chunk_t in_b_s  [STAGES];
  logic   in_c_s  [STAGES];
  logic   load_s  [STAGES];
  slice_t slice_s [STAGES];

  logic   stall_s;
  logic   accept_s;
  word_t  src_b_s;
  logic   src_c_s;

  // Only a valid but unaccepted result at the output stage can stall.
  assign stall_s      = v_r[STAGES-1] && !bus.out_ready;
  assign accept_s     = bus.in_valid && !stall_s;
  assign bus.in_ready = !stall_s;

  // Operand conditioning at capture time. Subtraction becomes x + ~y + 1.
  always_comb begin
    if (bus.op) begin
      src_b_s = ~bus.y;
      src_c_s = 1'b1;
    end else begin
      src_b_s = bus.y;
      src_c_s = bus.cin;
    end
  end

  // Select each stage's slice operands. Stage 0 adds straight from the bus;
  // later stages add from the previous stage's registers.
  always_comb begin
    in_a_s[0] = bus.x[CHUNK-1:0];
    in_b_s[0] = src_b_s[CHUNK-1:0];
    in_c_s[0] = src_c_s;
    load_s[0] = accept_s;
    for (int k = 1; k < STAGES; k++) begin
      in_a_s[k] = a_r[k-1][k*CHUNK +: CHUNK];
      in_b_s[k] = b_r[k-1][k*CHUNK +: CHUNK];
      in_c_s[k] = c_r[k-1];
      load_s[k] = v_r[k-1];
    end
  end

  // One ripple slice adder per stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_s[k] = add_slice(in_a_s[k], in_b_s[k], in_c_s[k]);
    end
  end

  // Next-state of every stage. Data is only updated when the upstream entry
  // is valid, so that sum/cout keep the last result across bubbles.
  always_comb begin
    v_s[0] = accept_s;
    if (accept_s) begin
      a_s[0]              = bus.x;
      b_s[0]              = src_b_s;
      res_s[0]            = {WIDTH{1'b0}};
      res_s[0][CHUNK-1:0] = slice_s[0][CHUNK-1:0];
      c_s[0]              = slice_s[0][CHUNK];
    end else begin
      a_s[0]   = a_r[0];
      b_s[0]   = b_r[0];
      res_s[0] = res_r[0];
      c_s[0]   = c_r[0];
    end
    for (int k = 1; k < STAGES; k++) begin
      v_s[k] = v_r[k-1];
      if (v_r[k-1]) begin
        a_s[k]                     = a_r[k-1];
        b_s[k]                     = b_r[k-1];
        res_s[k]                   = res_r[k-1];
        res_s[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
        c_s[k]                     = slice_s[k][CHUNK];
      end else begin
        a_s[k]   = a_r[k];
        b_s[k]   = b_r[k];
        res_s[k] = res_r[k];
        c_s[k]   = c_r[k];
      end
    end
  end

  // Stage registers. Reset clears everything; a stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= 1'b0;
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        res_r[k] <= {WIDTH{1'b0}};
        c_r[k]   <= 1'b0;
      end
    end else if (!stall_s) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= v_s[k];
        a_r[k]   <= a_s[k];
        b_r[k]   <= b_s[k];
        res_r[k] <= res_s[k];
        c_r[k]   <= c_s[k];
      end
    end
  end

  assign bus.out_valid = v_r[STAGES-1];
  assign bus.sum       = res_r[STAGES-1];
  assign bus.cout      = c_r[STAGES-1];

`ifdef PIPELINED_RCA_OVF_EN
  logic ovf_r;
  logic ovf_s;

  // The overflow flag is produced by the top slice alongside the final result.
  always_comb begin
    if (load_s[STAGES-1]) begin
      ovf_s = slice_ovf(in_a_s[STAGES-1], in_b_s[STAGES-1], in_c_s[STAGES-1]);
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Overflow register, which follows the output stage's reset/stall behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (!stall_s) begin
      ovf_r <= ovf_s;
    end
  end

  assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca. It uses directed vectors with
// hand-computed results on a WIDTH=8/STAGES=4 instance, and a streamed
// sweep against a reference model on STAGES=1 and STAGES=8 instances.
module tb_pipelined_rca;

  localparam int N_SWEEP = 4096;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_rca_if #(.WIDTH(8)) m_if  ();
  pipelined_rca_if #(.WIDTH(8)) s1_if ();
  pipelined_rca_if #(.WIDTH(8)) s8_if ();

  pipelined_rca #(.WIDTH(8), .STAGES(4)) dut    (.clk(clk), .rst(rst), .bus(m_if));
  pipelined_rca #(.WIDTH(8), .STAGES(1)) dut_s1 (.clk(clk), .rst(rst), .bus(s1_if));
  pipelined_rca #(.WIDTH(8), .STAGES(8)) dut_s8 (.clk(clk), .rst(rst), .bus(s8_if));

  int num_checks = 0;
  int num_errors = 0;

  logic [7:0] vx [N_SWEEP];
  logic [7:0] vy [N_SWEEP];
  logic       vc [N_SWEEP];
  logic       vo [N_SWEEP];

  logic [7:0] bp_x   [6] = '{8'd1, 8'd3, 8'd10, 8'd50, 8'd100, 8'd255};
  logic [7:0] bp_y   [6] = '{8'd2, 8'd4, 8'd20, 8'd60, 8'd100, 8'd1};
  logic [8:0] bp_exp [6] = '{9'd3, 9'd7, 9'd30, 9'd110, 9'd200, 9'd256};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic o);
    logic [7:0] bb;
    logic       cc;
    bb = o ? ~b : b;
    cc = o ? 1'b1 : c;
    return {1'b0, a} + {1'b0, bb} + {8'd0, cc};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic c,
                                   input logic o);
    logic [7:0] bb;
    logic [8:0] r;
    bb = o ? ~b : b;
    r  = ref_add(a, b, c, o);
    return (a[7] == bb[7]) && (r[7] != a[7]);
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic o);
    m_if.in_valid = 1'b1;
    m_if.x        = a;
    m_if.y        = b;
    m_if.cin      = c;
    m_if.op       = o;
  endtask

  task automatic idle();
    m_if.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int         sent;
    int         got;
    int         stall_left;
    logic       stalled_once;
    logic [8:0] held;
    logic [8:0] r;

    rst = 1'b1;
    m_if.in_valid = 1'b0; m_if.x = 8'd0; m_if.y = 8'd0; m_if.cin = 1'b0; m_if.op = 1'b0;
    m_if.out_ready = 1'b1;
    s1_if.in_valid = 1'b0; s1_if.x = 8'd0; s1_if.y = 8'd0; s1_if.cin = 1'b0; s1_if.op = 1'b0;
    s1_if.out_ready = 1'b1;
    s8_if.in_valid = 1'b0; s8_if.x = 8'd0; s8_if.y = 8'd0; s8_if.cin = 1'b0; s8_if.op = 1'b0;
    s8_if.out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    check_eq("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    check_eq("rst_sum",       32'(m_if.sum),       32'd0);
    check_eq("rst_cout",      32'(m_if.cout),      32'd0);
    check_eq("rst_in_ready",  32'(m_if.in_ready),  32'd1);
`ifdef PIPELINED_RCA_OVF_EN
    check_eq("rst_ovf",       32'(m_if.ovf),       32'd0);
`endif

    // Back-to-back adds, latency 4, one result per cycle
    drive(8'd217, 8'd65, 1'b0, 1'b0);  step();
    drive(8'd200, 8'd150, 1'b0, 1'b0); step();
    drive(8'd110, 8'd221, 1'b1, 1'b0); step();
    idle();
    check_eq("add_latency_early", 32'(m_if.out_valid), 32'd0);
    step();
    check_eq("add0_valid", 32'(m_if.out_valid), 32'd1);
    check_eq("add0", 32'({m_if.cout, m_if.sum}), 32'd282);
    step();
    check_eq("add1_valid", 32'(m_if.out_valid), 32'd1);
    check_eq("add1", 32'({m_if.cout, m_if.sum}), 32'd350);
    step();
    check_eq("add2_valid", 32'(m_if.out_valid), 32'd1);
    check_eq("add2", 32'({m_if.cout, m_if.sum}), 32'd332);
    step();
    check_eq("add_drained", 32'(m_if.out_valid), 32'd0);

    // Subtract, cin ignored
    drive(8'd100, 8'd30, 1'b1, 1'b1);  step();
    drive(8'd30, 8'd100, 1'b1, 1'b1);  step();
    idle(); step(); step();
    check_eq("sub0", 32'({m_if.out_valid, m_if.cout, m_if.sum}), 32'({1'b1, 1'b1, 8'd70}));
    step();
    check_eq("sub1", 32'({m_if.out_valid, m_if.cout, m_if.sum}), 32'({1'b1, 1'b0, 8'd186}));
    step();

    // Backpressure: a 3-cycle stall once the first result shows up
    sent = 0; got = 0; stall_left = 0; stalled_once = 1'b0; held = 9'd0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (m_if.out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left   = 3;
        held         = {m_if.cout, m_if.sum};
      end
      m_if.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (!m_if.out_ready) begin
        check_eq("bp_in_ready",   32'(m_if.in_ready),  32'd0);
        check_eq("bp_hold_valid", 32'(m_if.out_valid), 32'd1);
        check_eq("bp_hold",       32'({m_if.cout, m_if.sum}), 32'(held));
      end else if (m_if.out_valid) begin
        check_eq("bp_result", 32'({m_if.cout, m_if.sum}), 32'(bp_exp[got]));
        got++;
      end
      if (sent < 6 && m_if.in_ready) begin
        drive(bp_x[sent], bp_y[sent], 1'b0, 1'b0);
        sent++;
      end else begin
        idle();
      end
      step();
    end
    m_if.out_ready = 1'b1;
    idle();
    check_eq("bp_count", 32'(got), 32'd6);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_no_dup", 32'(m_if.out_valid), 32'd0);
      step();
    end

    // Reset while three operations are in flight
    drive(8'd9, 8'd9, 1'b0, 1'b0); step();
    drive(8'd1, 8'd1, 1'b0, 1'b0); step();
    drive(8'd2, 8'd2, 1'b0, 1'b1); step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(m_if.out_valid), 32'd0);
    check_eq("mid_rst_sum",   32'({m_if.cout, m_if.sum}), 32'd0);
    drive(8'd5, 8'd7, 1'b0, 1'b0); step();
    idle();
    for (int i = 1; i < 4; i++) begin
      check_eq("mid_rst_no_ghost", 32'(m_if.out_valid), 32'd0);
      step();
    end
    check_eq("post_rst", 32'({m_if.out_valid, m_if.cout, m_if.sum}), 32'({1'b1, 1'b0, 8'd12}));
    step();

`ifdef PIPELINED_RCA_OVF_EN
    // Signed overflow flag
    drive(8'd100, 8'd100, 1'b0, 1'b0); step();
    drive(8'd100, 8'd27, 1'b0, 1'b0);  step();
    drive(8'd128, 8'd1, 1'b0, 1'b1);   step();
    idle(); step();
    check_eq("ovf0", 32'({m_if.ovf, m_if.cout, m_if.sum}), 32'({1'b1, 1'b0, 8'd200}));
    step();
    check_eq("ovf1", 32'({m_if.ovf, m_if.cout, m_if.sum}), 32'({1'b0, 1'b0, 8'd127}));
    step();
    check_eq("ovf2", 32'({m_if.ovf, m_if.cout, m_if.sum}), 32'({1'b1, 1'b1, 8'd127}));
    step();
`endif

    // Streamed sweep on STAGES=1 and STAGES=8 against the reference model
    for (int i = 0; i < N_SWEEP; i++) begin
      vx[i] = 8'(i * 131 + (i >> 8) * 7);
      vy[i] = 8'(i * 53 + (i >> 4));
      vc[i] = 1'($urandom_range(0, 1));
      vo[i] = 1'($urandom_range(0, 1));
    end
    vx[0] = 8'd255; vy[0] = 8'd255;
    vx[1] = 8'd0;   vy[1] = 8'd0;
    vx[2] = 8'd255; vy[2] = 8'd0;
    vx[3] = 8'd0;   vy[3] = 8'd255;
    for (int i = 0; i < N_SWEEP + 8; i++) begin
      if (i < N_SWEEP) begin
        s1_if.in_valid = 1'b1; s1_if.x = vx[i]; s1_if.y = vy[i]; s1_if.cin = vc[i]; s1_if.op = vo[i];
        s8_if.in_valid = 1'b1; s8_if.x = vx[i]; s8_if.y = vy[i]; s8_if.cin = vc[i]; s8_if.op = vo[i];
      end else begin
        s1_if.in_valid = 1'b0;
        s8_if.in_valid = 1'b0;
      end
      step();
      if (i < N_SWEEP) begin
        r = ref_add(vx[i], vy[i], vc[i], vo[i]);
        check_eq("s1_valid", 32'(s1_if.out_valid), 32'd1);
        check_eq("s1_result", 32'({s1_if.cout, s1_if.sum}), 32'(r));
`ifdef PIPELINED_RCA_OVF_EN
        check_eq("s1_ovf", 32'(s1_if.ovf), 32'(ref_ovf(vx[i], vy[i], vc[i], vo[i])));
`endif
      end
      if (i >= 7 && i - 7 < N_SWEEP) begin
        r = ref_add(vx[i-7], vy[i-7], vc[i-7], vo[i-7]);
        check_eq("s8_valid", 32'(s8_if.out_valid), 32'd1);
        check_eq("s8_result", 32'({s8_if.cout, s8_if.sum}), 32'(r));
`ifdef PIPELINED_RCA_OVF_EN
        check_eq("s8_ovf", 32'(s8_if.ovf), 32'(ref_ovf(vx[i-7], vy[i-7], vc[i-7], vo[i-7])));
`endif
      end else if (i < 7) begin
        check_eq("s8_latency", 32'(s8_if.out_valid), 32'd0);
      end
    end
    check_eq("s1_drained", 32'(s1_if.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
